// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Arbitrates two register-file writeback requesters (ALU and load) into a
// single one-entry output stage that drives the register file write port.
// A write to R15 is steered to the PC write port instead.
//
// Ports
//   i_clk_w, i_rst_w             clock, asynchronous active-high reset
//   i_req0_valid/addr/data_w     requester 0 (ALU writeback) offer
//   o_req0_ready_w               requester 0 accepted this cycle
//   i_req1_valid/addr/data_w     requester 1 (load writeback) offer
//   o_req1_ready_w               requester 1 accepted this cycle
//   i_hold_w                     freeze the output stage, no write this cycle
//   o_reg_write_w/addr/data_w    register file write port
//   o_pc_write_w, o_pc_data_w    R15 write redirected to PC logic
//   o_pending_w                  one-hot of the address held in the stage
//   o_conflict_cnt_w             saturating count of refused-offer cycles
// ---------------------------------------------------------------------------
module regfile_wb_arbiter (
    input  logic        i_clk_w,
    input  logic        i_rst_w,
    input  logic        i_req0_valid_w,
    input  logic [3:0]  i_req0_addr_w,
    input  logic [31:0] i_req0_data_w,
    output logic        o_req0_ready_w,
    input  logic        i_req1_valid_w,
    input  logic [3:0]  i_req1_addr_w,
    input  logic [31:0] i_req1_data_w,
    output logic        o_req1_ready_w,
    input  logic        i_hold_w,
    output logic        o_reg_write_w,
    output logic [3:0]  o_write_addr_w,
    output logic [31:0] o_write_data_w,
    output logic        o_pc_write_w,
    output logic [31:0] o_pc_data_w,
    output logic [15:0] o_pending_w,
    output logic [7:0]  o_conflict_cnt_w
);

    localparam logic [3:0] PC_ADDR = 4'd15;

    logic        stage_valid;
    logic [3:0]  stage_addr;
    logic [31:0] stage_data;
    logic        favour_one;
    logic [7:0]  conflict_cnt;

    logic stage_free;
    logic grant0;
    logic grant1;
    logic ready0;
    logic ready1;
    logic drain;
    logic refused;

    // The stage can take a new entry if it is empty or is draining this cycle.
    // Ready is gated by reset so both handshakes stay low while reset is high,
    // even though the offers themselves are combinational inputs.
    always_comb begin
        stage_free = !stage_valid || !i_hold_w;
        grant0     = i_req0_valid_w && (!i_req1_valid_w || !favour_one);
        grant1     = i_req1_valid_w && (!i_req0_valid_w || favour_one);
        ready0     = stage_free && grant0 && !i_rst_w;
        ready1     = stage_free && grant1 && !i_rst_w;
        drain      = stage_valid && !i_hold_w;
        refused    = (i_req0_valid_w && !ready0) || (i_req1_valid_w && !ready1);
    end

    assign o_req0_ready_w   = ready0;
    assign o_req1_ready_w   = ready1;
    assign o_reg_write_w    = drain && (stage_addr != PC_ADDR);
    assign o_pc_write_w     = drain && (stage_addr == PC_ADDR);
    assign o_write_addr_w   = stage_valid ? stage_addr : 4'd0;
    assign o_write_data_w   = stage_valid ? stage_data : 32'd0;
    assign o_pc_data_w      = stage_valid ? stage_data : 32'd0;
    assign o_pending_w      = stage_valid ? (16'h0001 << stage_addr) : 16'h0000;
    assign o_conflict_cnt_w = conflict_cnt;

    // A handshake always wins over a drain so back-to-back writes need no
    // bubble. The round-robin pointer moves only on an accepted handshake and
    // then favours whichever requester was not just served.
    always_ff @(posedge i_clk_w or posedge i_rst_w) begin
        if (i_rst_w) begin
            stage_valid  <= 1'b0;
            stage_addr   <= 4'd0;
            stage_data   <= 32'd0;
            favour_one   <= 1'b0;
            conflict_cnt <= 8'd0;
        end else begin
            if (ready0 || ready1) begin
                stage_valid <= 1'b1;
                stage_addr  <= ready1 ? i_req1_addr_w : i_req0_addr_w;
                stage_data  <= ready1 ? i_req1_data_w : i_req0_data_w;
                favour_one  <= ready0;
            end else if (drain) begin
                stage_valid <= 1'b0;
            end
            if (refused && (conflict_cnt != 8'hFF)) begin
                conflict_cnt <= conflict_cnt + 8'd1;
            end
        end
    end

endmodule
